// File: rtl/op_lut_ip_checksum_ttl.sv
// op_lut_ip_checksum_ttl: snoops the lookup input stream, checks the IPv4 header checksum/TTL
// and queues one precomputed {flags, new TTL, new checksum} entry per packet.
module op_lut_ip_checksum_ttl #(
    parameter int                    DATA_WIDTH           = 64,
    parameter int                    CTRL_WIDTH           = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM        = 8'hff,
    parameter int                    INFO_FIFO_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    input  logic                  rd_preprocess_info,
    output logic                  ip_checksum_vld,
    output logic                  ip_checksum_is_good,
    output logic                  ip_hdr_has_options,
    output logic                  ip_ttl_is_good,
    output logic [7:0]            ip_new_ttl,
    output logic [15:0]           ip_new_checksum,
    output logic                  info_overflow
);
    localparam int DEPTH = 1 << INFO_FIFO_DEPTH_BITS;
    localparam int PW    = INFO_FIFO_DEPTH_BITS;
    localparam int CW    = INFO_FIFO_DEPTH_BITS + 1;

    typedef enum logic [1:0] {SYNC, HDRS, PKT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   chk_q, chk_d;
    logic [15:0]   new_q, new_d;
    logic          eth_ok_q, eth_ok_d;
    logic          opt_q, opt_d;
    logic [7:0]    ttl_q, ttl_d;
    logic          short_q, short_d;
    logic          eval_q, eval_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [26:0]   mem_q [DEPTH];
    logic [26:0]   mem_d [DEPTH];
    logic [7:0]    ttl_dec;
    logic [26:0]   entry;
    logic [26:0]   head;
    logic          pop;
    logic          push;
    logic          full;

    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        chk_d    = chk_q;
        new_d    = new_q;
        eth_ok_d = eth_ok_q;
        opt_d    = opt_q;
        ttl_d    = ttl_q;
        short_d  = short_q;
        eval_d   = 1'b0;
        ttl_dec  = (in_data[15:8] == 8'd0) ? 8'd0 : in_data[15:8] - 8'd1;
        if (in_wr) begin
            case (state_q)
                SYNC: state_d = (in_ctrl == IOQ_STAGE_NUM) ? HDRS : SYNC;
                HDRS: begin
                    if (in_ctrl == '0) begin
                        state_d  = PKT;
                        idx_d    = 3'd1;
                        chk_d    = 16'd0;
                        new_d    = 16'd0;
                        eth_ok_d = 1'b0;
                        opt_d    = 1'b0;
                        ttl_d    = 8'd0;
                        short_d  = 1'b0;
                    end
                end
                PKT: begin
                    case (idx_q)
                        3'd1: begin
                            chk_d    = oc_add(chk_q, in_data[15:0]);
                            new_d    = oc_add(new_q, in_data[15:0]);
                            eth_ok_d = in_data[31:16] == 16'h0800;
                            opt_d    = in_data[15:8] != 8'h45;
                        end
                        3'd2: begin
                            chk_d = oc_add(oc_add(oc_add(oc_add(chk_q, in_data[63:48]), in_data[47:32]),
                                                  in_data[31:16]), in_data[15:0]);
                            new_d = oc_add(oc_add(oc_add(oc_add(new_q, in_data[63:48]), in_data[47:32]),
                                                  in_data[31:16]), {ttl_dec, in_data[7:0]});
                            ttl_d = in_data[15:8];
                        end
                        3'd3: begin
                            chk_d = oc_add(oc_add(oc_add(oc_add(chk_q, in_data[63:48]), in_data[47:32]),
                                                  in_data[31:16]), in_data[15:0]);
                            new_d = oc_add(oc_add(oc_add(new_q, in_data[47:32]), in_data[31:16]),
                                           in_data[15:0]);
                        end
                        3'd4: begin
                            chk_d = oc_add(chk_q, in_data[63:48]);
                            new_d = oc_add(new_q, in_data[63:48]);
                        end
                        default: ;
                    endcase
                    idx_d   = (idx_q == 3'd5) ? 3'd5 : idx_q + 3'd1;
                    // A last word ahead of w4 ends the header early; evaluate then, flagged short.
                    eval_d  = (idx_q == 3'd4) || (in_ctrl != '0 && idx_q < 3'd4);
                    short_d = (in_ctrl != '0 && idx_q < 3'd4) ? 1'b1 : short_q;
                    state_d = (in_ctrl != '0) ? HDRS : PKT;
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_comb begin
        entry = {(chk_q == 16'hffff) & eth_ok_q & ~short_q, opt_q, ttl_q > 8'd1,
                 (ttl_q == 8'd0) ? 8'd0 : ttl_q - 8'd1, ~new_q};
        full  = cnt_q == CW'(DEPTH);
        pop   = rd_preprocess_info && cnt_q != '0;
        // A full FIFO still accepts the push when the head is popped in the same cycle.
        push  = eval_q && (!full || pop);
        info_overflow = eval_q && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = entry;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= SYNC;
            idx_q    <= 3'd0;
            chk_q    <= 16'd0;
            new_q    <= 16'd0;
            eth_ok_q <= 1'b0;
            opt_q    <= 1'b0;
            ttl_q    <= 8'd0;
            short_q  <= 1'b0;
            eval_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            chk_q    <= chk_d;
            new_q    <= new_d;
            eth_ok_q <= eth_ok_d;
            opt_q    <= opt_d;
            ttl_q    <= ttl_d;
            short_q  <= short_d;
            eval_q   <= eval_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head                = mem_q[rd_ptr_q];
    assign ip_checksum_vld     = cnt_q != '0;
    assign ip_checksum_is_good = ip_checksum_vld & head[26];
    assign ip_hdr_has_options  = ip_checksum_vld & head[25];
    assign ip_ttl_is_good      = ip_checksum_vld & head[24];
    assign ip_new_ttl          = ip_checksum_vld ? head[23:16] : 8'd0;
    assign ip_new_checksum     = ip_checksum_vld ? head[15:0] : 16'd0;
endmodule

// File: tb/tb_op_lut_ip_checksum_ttl.sv
// tb_op_lut_ip_checksum_ttl: directed vectors with hand-computed header checksums.
module tb_op_lut_ip_checksum_ttl;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        rd;
    logic        vld, good, opt, ttl_good, ovf;
    logic [7:0]  new_ttl;
    logic [15:0] new_chk;
    int          checks = 0;
    int          errors = 0;
    int          ovf_cnt = 0;

    op_lut_ip_checksum_ttl dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .rd_preprocess_info(rd), .ip_checksum_vld(vld), .ip_checksum_is_good(good),
        .ip_hdr_has_options(opt), .ip_ttl_is_good(ttl_good), .ip_new_ttl(new_ttl),
        .ip_new_checksum(new_chk), .info_overflow(ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ovf) ovf_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic entry(input string tag, input logic g, input logic o, input logic tg,
                         input logic [7:0] nt, input logic [15:0] nc);
        check({tag, "_vld"}, 32'(vld), 32'd1);
        check({tag, "_good"}, 32'(good), 32'(g));
        check({tag, "_opt"}, 32'(opt), 32'(o));
        check({tag, "_ttlgood"}, 32'(ttl_good), 32'(tg));
        check({tag, "_newttl"}, 32'(new_ttl), 32'(nt));
        check({tag, "_newchk"}, 32'(new_chk), 32'(nc));
    endtask

    function automatic logic [63:0] word(input int i, input logic [15:0] eth, input logic [7:0] vi,
                                         input logic [7:0] ttl, input logic [15:0] cks);
        case (i)
            1: return {32'h0011_2233, eth, vi, 8'h00};
            2: return {48'h0073_0000_4000, ttl, 8'h11};
            3: return {cks, 48'hc0a8_0001_c0a8};
            4: return {16'h00c7, 48'h0};
            5: return 64'h0000_0000_dead_beef;
            default: return 64'h0;
        endcase
    endfunction

    task automatic wr(input logic [7:0] c, input logic [63:0] d);
        in_wr = 1'b1;
        in_ctrl = c;
        in_data = d;
        tick();
        in_wr = 1'b0;
        in_ctrl = 8'h00;
        in_data = 64'h0;
    endtask

    task automatic pkt(input logic [15:0] eth, input logic [7:0] vi, input logic [7:0] ttl,
                       input logic [15:0] cks, input int last, input logic pop_last);
        wr(8'hff, 64'h0);
        for (int i = 0; i <= last; i++) begin
            rd = (i == last) && pop_last;
            wr((i == last) ? 8'h80 : 8'h00, word(i, eth, vi, ttl, cks));
            rd = 1'b0;
        end
    endtask

    task automatic do_pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        in_wr = 1'b0;
        in_ctrl = 8'h00;
        in_data = 64'h0;
        rd = 1'b0;
        repeat (3) tick();
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_good", 32'(good), 32'd0);
        check("rst_newttl", 32'(new_ttl), 32'd0);
        check("rst_newchk", 32'(new_chk), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;
        tick();

        // valid header with latency check
        wr(8'hff, 64'h0);
        for (int i = 0; i <= 4; i++) wr(8'h00, word(i, 16'h0800, 8'h45, 8'h40, 16'hb861));
        check("lat_t1_vld", 32'(vld), 32'd0);
        wr(8'h80, word(5, 16'h0800, 8'h45, 8'h40, 16'hb861));
        entry("valid", 1'b1, 1'b0, 1'b1, 8'h3f, 16'hb961);
        do_pop();
        check("pop_empty_vld", 32'(vld), 32'd0);
        do_pop();
        check("pop_when_empty_vld", 32'(vld), 32'd0);

        pkt(16'h0800, 8'h45, 8'h40, 16'hb862, 5, 1'b0);
        tick();
        entry("badchk", 1'b0, 1'b0, 1'b1, 8'h3f, 16'hb961);
        do_pop();

        pkt(16'h0800, 8'h45, 8'h01, 16'hb861, 5, 1'b0);
        tick();
        entry("ttl01", 1'b0, 1'b0, 1'b0, 8'h00, 16'hf861);
        do_pop();

        pkt(16'h0800, 8'h45, 8'h00, 16'hb861, 5, 1'b0);
        tick();
        entry("ttl00", 1'b0, 1'b0, 1'b0, 8'h00, 16'hf861);
        do_pop();

        pkt(16'h0800, 8'h46, 8'h40, 16'hb861, 5, 1'b0);
        tick();
        check("ihl46_vld", 32'(vld), 32'd1);
        check("ihl46_opt", 32'(opt), 32'd1);
        check("ihl46_good", 32'(good), 32'd0);
        do_pop();

        pkt(16'h0806, 8'h45, 8'h40, 16'hb861, 5, 1'b0);
        tick();
        check("nonip_vld", 32'(vld), 32'd1);
        check("nonip_good", 32'(good), 32'd0);
        do_pop();
        check("nonip_single", 32'(vld), 32'd0);

        pkt(16'h0800, 8'h45, 8'h40, 16'hb861, 2, 1'b0);
        tick();
        check("short_vld", 32'(vld), 32'd1);
        check("short_good", 32'(good), 32'd0);
        do_pop();
        check("short_single", 32'(vld), 32'd0);

        // fill the 4-deep FIFO and overflow it once
        for (int i = 0; i < 4; i++) pkt(16'h0800, 8'h45, 8'h10 + 8'(i), 16'hb861, 5, 1'b0);
        check("full_no_ovf_yet", 32'(ovf_cnt), 32'd0);
        pkt(16'h0800, 8'h45, 8'h14, 16'hb861, 5, 1'b0);
        check("full_ovf_once", 32'(ovf_cnt), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("full_order", 32'(new_ttl), 32'h0f + 32'(i));
            do_pop();
        end
        check("full_drained", 32'(vld), 32'd0);

        // push and pop together while full
        for (int i = 0; i < 4; i++) pkt(16'h0800, 8'h45, 8'h20 + 8'(i), 16'hb861, 5, 1'b0);
        pkt(16'h0800, 8'h45, 8'h24, 16'hb861, 5, 1'b1);
        check("pushpop_no_ovf", 32'(ovf_cnt), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("pushpop_order", 32'(new_ttl), 32'h20 + 32'(i));
            do_pop();
        end
        check("pushpop_drained", 32'(vld), 32'd0);

        // mid-packet reset flushes a pending entry and drops the rest of packet A
        pkt(16'h0800, 8'h45, 8'h40, 16'hb861, 5, 1'b0);
        tick();
        check("pre_rst_vld", 32'(vld), 32'd1);
        wr(8'hff, 64'h0);
        wr(8'h00, word(0, 16'h0800, 8'h45, 8'h33, 16'hb861));
        wr(8'h00, word(1, 16'h0800, 8'h45, 8'h33, 16'hb861));
        reset = 1'b0;
        wr(8'h00, word(2, 16'h0800, 8'h45, 8'h33, 16'hb861));
        reset = 1'b1;
        wr(8'h00, word(3, 16'h0800, 8'h45, 8'h33, 16'hb861));
        wr(8'h00, word(4, 16'h0800, 8'h45, 8'h33, 16'hb861));
        wr(8'h80, word(5, 16'h0800, 8'h45, 8'h33, 16'hb861));
        repeat (2) tick();
        check("midrst_no_entry", 32'(vld), 32'd0);
        pkt(16'h0800, 8'h45, 8'h40, 16'hb861, 5, 1'b0);
        tick();
        entry("after_rst", 1'b1, 1'b0, 1'b1, 8'h3f, 16'hb961);
        do_pop();
        check("after_rst_drained", 32'(vld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
